// File: rtl/wb_stage_reg.sv
// -----------------------------------------------------------------------------
// wb_stage_reg -- M→W pipeline register for a 32-bit RISC-V style core.
//
// Purpose:
//   Captures the memory-stage results into the write-back stage. This includes:
//     - a reg_write qualification that suppresses writes to x0,
//     - optional load extension of the memory read data,
//     - an instruction-retired counter.
//   On each rising edge the actions are tried in this order:
//     reset > flush > stall > capture.
//
// Configuration:
//   WB_LOAD_EXT_EN  When this macro is defined, read_data_w is extended for
//                   loads (LB/LH/LW/LBU/LHU).
//                   When it is undefined, read_data_m is always passed through
//                   unchanged.
//
// Ports:
//   clk, reset         Clock and synchronous active-high reset.
//   stall_w            Hold every W register, including instret_w.
//   flush_w            Clear W control and data to a bubble. instret_w holds.
//   valid_m            The M slot holds a real instruction.
//   reg_write_m        The instruction writes rd.
//   result_src_m[1:0]  Result select: 00 ALU, 01 mem, 10 PC+4, 11 imm.
//   rd_m[4:0]          Destination register index.
//   funct3_m[2:0]      Load type.
//   addr_lo_m[1:0]     Byte offset of the load.
//   alu_result_m, read_data_m, pc_plus4_m, imm_ext_m   Result candidates.
//   valid_w, reg_write_w, result_src_w, rd_w           Registered control.
//   alu_result_w, read_data_w, pc_plus4_w, imm_ext_w   Registered data
//                                                      (result mux d0..d3).
//   instret_w[31:0]    Count of instructions retired into W. Wraps silently.
// -----------------------------------------------------------------------------
module wb_stage_reg #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            stall_w,
   input  logic            flush_w,
   input  logic            valid_m,
   input  logic            reg_write_m,
   input  logic [1:0]      result_src_m,
   input  logic [4:0]      rd_m,
   input  logic [2:0]      funct3_m,
   input  logic [1:0]      addr_lo_m,
   input  logic [XLEN-1:0] alu_result_m,
   input  logic [XLEN-1:0] read_data_m,
   input  logic [XLEN-1:0] pc_plus4_m,
   input  logic [XLEN-1:0] imm_ext_m,
   output logic            valid_w,
   output logic            reg_write_w,
   output logic [1:0]      result_src_w,
   output logic [4:0]      rd_w,
   output logic [XLEN-1:0] alu_result_w,
   output logic [XLEN-1:0] read_data_w,
   output logic [XLEN-1:0] pc_plus4_w,
   output logic [XLEN-1:0] imm_ext_w,
   output logic [31:0]     instret_w
);

`ifdef WB_LOAD_EXT_EN
   localparam bit LOAD_EXT_EN = 1'b1;
`else
   localparam bit LOAD_EXT_EN = 1'b0;
`endif

   logic            valid_reg;
   logic            reg_write_reg;
   logic [1:0]      result_src_reg;
   logic [4:0]      rd_reg;
   logic [XLEN-1:0] alu_result_reg;
   logic [XLEN-1:0] read_data_reg;
   logic [XLEN-1:0] pc_plus4_reg;
   logic [XLEN-1:0] imm_ext_reg;
   logic [31:0]     instret_reg;

   logic [31:0]     instret_next;
   logic [7:0]      load_byte;
   logic [15:0]     load_half;
   logic [XLEN-1:0] load_data;

   assign instret_next = instret_reg + 32'd1;

   // Select the byte or halfword that the load addresses. Bit 0 of the offset
   // is ignored for halfwords, so a misaligned LH reads the aligned half.
   always_comb begin
      load_byte = read_data_m[7:0];
      case (addr_lo_m)
         2'd0:    load_byte = read_data_m[7:0];
         2'd1:    load_byte = read_data_m[15:8];
         2'd2:    load_byte = read_data_m[23:16];
         default: load_byte = read_data_m[31:24];
      endcase
      load_half = addr_lo_m[1] ? read_data_m[31:16] : read_data_m[15:0];
   end

   // Only memory results are extended. Any other result_src passes the
   // memory data through unchanged. So do unknown funct3 codes.
   always_comb begin
      load_data = read_data_m;
      if (LOAD_EXT_EN && (result_src_m == 2'b01)) begin
         case (funct3_m)
            3'b000:  load_data = {{(XLEN-8){load_byte[7]}}, load_byte};
            3'b001:  load_data = {{(XLEN-16){load_half[15]}}, load_half};
            3'b100:  load_data = {{(XLEN-8){1'b0}}, load_byte};
            3'b101:  load_data = {{(XLEN-16){1'b0}}, load_half};
            default: load_data = read_data_m;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_reg      <= 1'b0;
         reg_write_reg  <= 1'b0;
         result_src_reg <= 2'b00;
         rd_reg         <= 5'd0;
         alu_result_reg <= '0;
         read_data_reg  <= '0;
         pc_plus4_reg   <= '0;
         imm_ext_reg    <= '0;
         instret_reg    <= 32'd0;
      end else if (flush_w) begin
         // Insert a bubble. The retired count is not touched.
         valid_reg      <= 1'b0;
         reg_write_reg  <= 1'b0;
         result_src_reg <= 2'b00;
         rd_reg         <= 5'd0;
         alu_result_reg <= '0;
         read_data_reg  <= '0;
         pc_plus4_reg   <= '0;
         imm_ext_reg    <= '0;
      end else if (!stall_w) begin
         valid_reg      <= valid_m;
         // Writes to x0 and bubbles never reach the register file.
         reg_write_reg  <= reg_write_m & valid_m & (rd_m != 5'd0);
         result_src_reg <= result_src_m;
         rd_reg         <= rd_m;
         alu_result_reg <= alu_result_m;
         read_data_reg  <= load_data;
         pc_plus4_reg   <= pc_plus4_m;
         imm_ext_reg    <= imm_ext_m;
         if (valid_m) begin
            instret_reg <= instret_next;
         end
      end
   end

   assign valid_w      = valid_reg;
   assign reg_write_w  = reg_write_reg;
   assign result_src_w = result_src_reg;
   assign rd_w         = rd_reg;
   assign alu_result_w = alu_result_reg;
   assign read_data_w  = read_data_reg;
   assign pc_plus4_w   = pc_plus4_reg;
   assign imm_ext_w    = imm_ext_reg;
   assign instret_w    = instret_reg;

endmodule

// File: tb/tb_wb_stage_reg.sv
// -----------------------------------------------------------------------------
// tb_wb_stage_reg -- self-checking bench for wb_stage_reg.
//
// Every drive pushes the expected W-stage state onto a scoreboard queue.
// After the clock edge, that entry is popped and compared field by field.
// Load extension is expected only when WB_LOAD_EXT_EN is defined.
// -----------------------------------------------------------------------------
module tb_wb_stage_reg;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall_w, flush_w, valid_m, reg_write_m;
   logic [1:0]  result_src_m;
   logic [4:0]  rd_m;
   logic [2:0]  funct3_m;
   logic [1:0]  addr_lo_m;
   logic [31:0] alu_result_m, read_data_m, pc_plus4_m, imm_ext_m;
   logic        valid_w, reg_write_w;
   logic [1:0]  result_src_w;
   logic [4:0]  rd_w;
   logic [31:0] alu_result_w, read_data_w, pc_plus4_w, imm_ext_w, instret_w;

   wb_stage_reg #(.XLEN(32)) dut (
      .clk(clk), .reset(reset), .stall_w(stall_w), .flush_w(flush_w),
      .valid_m(valid_m), .reg_write_m(reg_write_m), .result_src_m(result_src_m),
      .rd_m(rd_m), .funct3_m(funct3_m), .addr_lo_m(addr_lo_m),
      .alu_result_m(alu_result_m), .read_data_m(read_data_m),
      .pc_plus4_m(pc_plus4_m), .imm_ext_m(imm_ext_m),
      .valid_w(valid_w), .reg_write_w(reg_write_w), .result_src_w(result_src_w),
      .rd_w(rd_w), .alu_result_w(alu_result_w), .read_data_w(read_data_w),
      .pc_plus4_w(pc_plus4_w), .imm_ext_w(imm_ext_w), .instret_w(instret_w)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        valid;
      logic        rw;
      logic [1:0]  rs;
      logic [4:0]  rd;
      logic [31:0] alu;
      logic [31:0] rdata;
      logic [31:0] pc;
      logic [31:0] imm;
      logic [31:0] cnt;
   } exp_t;

   exp_t exp_q[$];
   exp_t model;          // expected W-stage state
   int   checks   = 0;
   int   failures = 0;
   int   txn      = 0;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (txn %0d)", tag, act, req, txn);
      end
   endtask

   // Reference load extension, written from the instruction definitions.
   function automatic logic [31:0] ref_rdata(input logic [1:0] rs, input logic [2:0] f3,
                                              input logic [1:0] a, input logic [31:0] d);
      logic [31:0] sb, sh;
      sb = d >> (32'(a) * 8);
      sh = d >> (a[1] ? 16 : 0);
      ref_rdata = d;
`ifdef WB_LOAD_EXT_EN
      if (rs == 2'b01) begin
         case (f3)
            3'b000:  ref_rdata = 32'($signed(sb[7:0]));
            3'b001:  ref_rdata = 32'($signed(sh[15:0]));
            3'b100:  ref_rdata = {24'd0, sb[7:0]};
            3'b101:  ref_rdata = {16'd0, sh[15:0]};
            default: ref_rdata = d;
         endcase
      end
`else
      if (rs == 2'b01 && f3 == 3'b111) ref_rdata = d;   // always pass-through
`endif
   endfunction

   // One transaction: drive at negedge, update model, push, clock, pop, compare.
   task automatic drive(input logic r, input logic fl, input logic st, input logic v,
                        input logic rw, input logic [1:0] rs, input logic [4:0] rd,
                        input logic [2:0] f3, input logic [1:0] a, input logic [31:0] alu,
                        input logic [31:0] rdat, input logic [31:0] pc, input logic [31:0] imm);
      exp_t e;
      @(negedge clk);
      reset = r; flush_w = fl; stall_w = st; valid_m = v; reg_write_m = rw;
      result_src_m = rs; rd_m = rd; funct3_m = f3; addr_lo_m = a;
      alu_result_m = alu; read_data_m = rdat; pc_plus4_m = pc; imm_ext_m = imm;
      if (r) begin
         model = '0;
      end else if (fl) begin
         model.valid = 0; model.rw = 0; model.rs = 0; model.rd = 0;
         model.alu = 0; model.rdata = 0; model.pc = 0; model.imm = 0;
      end else if (!st) begin
         model.valid = v;
         model.rw    = rw && v && (rd != 0);
         model.rs    = rs;
         model.rd    = rd;
         model.alu   = alu;
         model.rdata = ref_rdata(rs, f3, a, rdat);
         model.pc    = pc;
         model.imm   = imm;
         if (v) model.cnt = model.cnt + 1;
      end
      exp_q.push_back(model);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      txn++;
      check_eq("valid_w",      32'(valid_w),      32'(e.valid));
      check_eq("reg_write_w",  32'(reg_write_w),  32'(e.rw));
      check_eq("result_src_w", 32'(result_src_w), 32'(e.rs));
      check_eq("rd_w",         32'(rd_w),         32'(e.rd));
      check_eq("alu_result_w", alu_result_w,      e.alu);
      check_eq("read_data_w",  read_data_w,       e.rdata);
      check_eq("pc_plus4_w",   pc_plus4_w,        e.pc);
      check_eq("imm_ext_w",    imm_ext_w,         e.imm);
      check_eq("instret_w",    instret_w,         e.cnt);
      $display("txn %0d rst=%0b fl=%0b st=%0b v=%0b rw_w=%0b rd_w=%0d rdata_w=%08h instret_w=%08h",
               txn, r, fl, st, v, reg_write_w, rd_w, read_data_w, instret_w);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      model = '0;
      reset = 1; stall_w = 0; flush_w = 0; valid_m = 0; reg_write_m = 0;
      result_src_m = 0; rd_m = 0; funct3_m = 0; addr_lo_m = 0;
      alu_result_m = 0; read_data_m = 0; pc_plus4_m = 0; imm_ext_m = 0;

      // Reset with stall and flush also asserted: reset must win.
      drive(1, 1, 1, 1, 1, 2'b01, 5'd3, 3'b000, 2'b00, 32'h1, 32'h2, 32'h3, 32'h4);
      drive(1, 0, 0, 0, 0, 2'b00, 5'd0, 3'b000, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);

      // LB sign extension, offset 3.
      drive(0, 0, 0, 1, 1, 2'b01, 5'd5, 3'b000, 2'b11, 32'h1003, 32'h8812F0AB, 32'h104, 32'h7);
      // LHU zero extension, upper half.
      drive(0, 0, 0, 1, 1, 2'b01, 5'd6, 3'b101, 2'b10, 32'h1002, 32'h8812F0AB, 32'h108, 32'h8);
      // LH with odd offset (bit 0 ignored), LBU, LW, odd funct3, non-load.
      drive(0, 0, 0, 1, 1, 2'b01, 5'd7, 3'b001, 2'b01, 32'h1001, 32'h8812F0AB, 32'h10C, 32'h9);
      drive(0, 0, 0, 1, 1, 2'b01, 5'd8, 3'b100, 2'b01, 32'h1001, 32'h8812F0AB, 32'h110, 32'hA);
      drive(0, 0, 0, 1, 1, 2'b01, 5'd9, 3'b010, 2'b00, 32'h1000, 32'h8812F0AB, 32'h114, 32'hB);
      drive(0, 0, 0, 1, 1, 2'b01, 5'd10, 3'b011, 2'b00, 32'h1000, 32'h8812F0AB, 32'h118, 32'hC);
      drive(0, 0, 0, 1, 1, 2'b00, 5'd11, 3'b000, 2'b11, 32'h1003, 32'h8812F0AB, 32'h11C, 32'hD);
      drive(0, 0, 0, 1, 1, 2'b11, 5'd12, 3'b001, 2'b10, 32'h1002, 32'h00F0F0F0, 32'h120, 32'hE);

      // Write to x0 is suppressed but still retires. An invalid slot does not retire.
      drive(0, 0, 0, 1, 1, 2'b00, 5'd0, 3'b000, 2'b00, 32'hABCD, 32'h0, 32'h124, 32'h0);
      drive(0, 0, 0, 0, 1, 2'b10, 5'd4, 3'b000, 2'b00, 32'h5555, 32'h0, 32'h128, 32'h0);

      // Stall for three cycles while M changes, then stall and flush together.
      drive(0, 0, 0, 1, 1, 2'b10, 5'd13, 3'b000, 2'b00, 32'hCAFE, 32'h1, 32'h12C, 32'h2);
      for (int i = 0; i < 3; i++)
         drive(0, 0, 1, 1, 1, 2'(i), 5'(20 + i), 3'(i), 2'(i), $urandom, $urandom, $urandom, $urandom);
      drive(0, 1, 1, 1, 1, 2'b01, 5'd14, 3'b000, 2'b00, 32'h1, 32'h2, 32'h3, 32'h4);

      // Random traffic with occasional stall and flush.
      for (int i = 0; i < 40; i++)
         drive(0, ($urandom_range(0, 9) == 0), ($urandom_range(0, 4) == 0),
               1'($urandom), 1'($urandom), 2'($urandom), 5'($urandom), 3'($urandom),
               2'($urandom), $urandom, $urandom, $urandom, $urandom);

      // Reset in the middle of back-to-back captures, then one valid capture.
      drive(0, 0, 0, 1, 1, 2'b00, 5'd1, 3'b000, 2'b00, 32'h11, 32'h22, 32'h33, 32'h44);
      drive(1, 0, 0, 1, 1, 2'b00, 5'd2, 3'b000, 2'b00, 32'h55, 32'h66, 32'h77, 32'h88);
      drive(0, 0, 0, 1, 1, 2'b00, 5'd3, 3'b000, 2'b00, 32'h99, 32'hAA, 32'hBB, 32'hCC);

      // Counter wrap: force the incrementer so the next capture loads 0xFFFFFFFF.
      force dut.instret_next = 32'hFFFFFFFF;
      model.cnt = 32'hFFFFFFFE;
      drive(0, 0, 0, 1, 0, 2'b00, 5'd4, 3'b000, 2'b00, 32'h1, 32'h2, 32'h3, 32'h4);
      release dut.instret_next;
      drive(0, 0, 0, 1, 0, 2'b00, 5'd5, 3'b000, 2'b00, 32'h5, 32'h6, 32'h7, 32'h8);

      if (exp_q.size() != 0) check_eq("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/wb_stage_reg.md
WB_STAGE_REG -- requirements
Module: wb_stage_reg

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width; only 32 is supported.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port stall_w  input  1  hold all W-stage registers.
REQ-005 SHALL have port flush_w  input  1  insert a bubble into W.
REQ-006 SHALL have port valid_m  input  1  M-stage slot holds a real instruction.
REQ-007 SHALL have port reg_write_m  input  1  instruction writes rd.
REQ-008 SHALL have port result_src_m  input  2  result select: 00 ALU, 01 memory, 10 PC+4, 11 immediate.
REQ-009 SHALL have port rd_m  input  5  destination register index.
REQ-010 SHALL have port funct3_m  input  3  load type.
REQ-011 SHALL have port addr_lo_m  input  2  alu_result_m[1:0], the byte offset of the load.
REQ-012 SHALL have ports alu_result_m, read_data_m, pc_plus4_m, imm_ext_m  input  XLEN each  M-stage result candidates.
REQ-013 SHALL have outputs valid_w (1), reg_write_w (1), result_src_w (2), rd_w (5)  registered W-stage control.
REQ-014 SHALL have outputs alu_result_w, read_data_w, pc_plus4_w, imm_ext_w  XLEN each  registered data, driving the 4:1 result-select mux in order d0..d3.
REQ-015 SHALL have output instret_w  32  count of instructions retired into W.

Function
REQ-016 SHALL have a latency of exactly one cycle from M inputs to W outputs when stall_w=0 and flush_w=0.
REQ-017 SHALL use this per-edge priority: reset, then flush_w, then stall_w, then capture.
REQ-018 On flush_w=1, SHALL clear valid_w, reg_write_w, result_src_w, rd_w and all data outputs to 0; instret_w holds.
REQ-019 On stall_w=1 with flush_w=0, SHALL hold every output, including instret_w.
REQ-020 On capture, SHALL compute reg_write_w = reg_write_m AND valid_m AND (rd_m != 0).
REQ-021 On capture, SHALL register all other fields unchanged, except read_data_w, which follows REQ-022 and REQ-023.
REQ-022 When result_src_m=01, SHALL load-extend read_data_w from read_data_m as follows:
  - LB (000): byte selected by addr_lo_m, sign-extended.
  - LH (001): halfword selected by addr_lo_m[1], sign-extended; addr_lo_m[0] is ignored.
  - LW (010): full word.
  - LBU (100): byte selected by addr_lo_m, zero-extended.
  - LHU (101): halfword selected by addr_lo_m[1], zero-extended.
  - Any other funct3: full word.
REQ-023 When result_src_m != 01, SHALL capture read_data_w as read_data_m unmodified.
REQ-024 SHALL increment instret_w by 1 on each capture edge where valid_m=1.
REQ-025 SHALL wrap instret_w from 0xFFFFFFFF to 0x00000000 with no flag.
REQ-026 SHALL treat stall_w and flush_w asserted together as a flush.

Reset
REQ-027 While reset=1 at a rising edge, SHALL drive all outputs to 0, including instret_w, regardless of stall_w or flush_w.
REQ-028 SHALL discard any in-flight instruction on reset mid-operation; the first capture after reset deasserts SHALL behave per REQ-016.

Configuration
REQ-029 With macro WB_LOAD_EXT_EN defined, SHALL perform load extension per REQ-022.
REQ-030 With WB_LOAD_EXT_EN undefined, SHALL always capture read_data_w = read_data_m; all other behaviour is unchanged.

Verification
REQ-031 SHALL cover LB sign extension:
  - Stimulus: read_data_m=0x8812F0AB, result_src_m=01, funct3=000, addr_lo=11.
  - Response: read_data_w=0xFFFFFF88 after one edge.
  - With WB_LOAD_EXT_EN undefined: read_data_w=0x8812F0AB.
REQ-032 SHALL cover LHU zero extension:
  - Stimulus: same read_data_m, funct3=101, addr_lo=10.
  - Response: read_data_w=0x00008812.
REQ-033 SHALL cover rd=x0 suppression:
  - Stimulus: valid_m=1, reg_write_m=1, rd_m=0.
  - Response: reg_write_w=0, valid_w=1, instret_w increments by 1.
REQ-034 SHALL cover stall, then flush:
  - Stimulus: stall_w=1 for 3 cycles while M inputs change.
  - Response: W outputs and instret_w are frozen.
  - Then: flush_w=1 together with stall_w=1 gives valid_w=0 and reg_write_w=0 next cycle.
REQ-035 SHALL cover counter wrap:
  - Stimulus: preload instret_w to 0xFFFFFFFF via 2^32-1 captures or a force, then one valid capture.
  - Response: instret_w=0.
REQ-036 SHALL cover reset mid-stream:
  - Stimulus: reset=1 for one edge during back-to-back valid captures.
  - Response: all outputs 0 next cycle; the next valid capture gives instret_w=1.
